param_updown_counter: RTL and testbench
=======================================

Name: param_updown_counter

Overview:
- Parameterised synchronous up/down counter with programmable modulus, load, enable and prescaler. Replaces fixed 4-bit free-running counters in the sequential library.
- Supports two boundary modes: wrap or saturate.
- Provides a terminal-count flag, a one-cycle wrap pulse and sticky overflow/underflow flags, for use as timers, event counters and address generators.

Parameters:
- WIDTH, 4, counter width in bits (1..32).
- MODULUS, 16, count range 0..MODULUS-1; legal range 2..2**WIDTH.
- PRESCALE, 1, enabled cycles per count step; legal range 1..65535.
- RESET_VAL, 0, value of q after reset; must be < MODULUS.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- en  in  1  count enable, gates the prescaler.
- up_dn  in  1  1 = count up, 0 = count down.
- sat_mode  in  1  1 = saturate at boundary, 0 = wrap.
- load  in  1  synchronous load strobe.
- load_val  in  WIDTH  value to load.
- clr_flags  in  1  clears the sticky ovf/unf flags.
- q  out  WIDTH  current count, registered.
- tc  out  1  terminal count, combinational from q and up_dn.
- wrap_p  out  1  one-cycle registered pulse on a boundary event.
- ovf  out  1  sticky flag, upward boundary hit.
- unf  out  1  sticky flag, downward boundary hit.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: q=RESET_VAL, prescaler count=0, wrap_p=0, ovf=0, unf=0.
- Priority per cycle is rst > load > step.
- Load:
  - q <= min(load_val, MODULUS-1).
  - Prescaler count cleared to 0.
  - No flags change and wrap_p=0.
  - load wins over a coinciding step.
- Prescaler:
  - Internal counter 0..PRESCALE-1 advances only when en=1 and load=0.
  - A step tick occurs in a cycle where en=1 and the prescaler count = PRESCALE-1; the prescaler count then returns to 0.
  - PRESCALE=1 gives a tick on every enabled cycle.
  - en=0 freezes both the prescaler and q.
- Step, up (up_dn=1):
  - If q < MODULUS-1: q <= q+1.
  - If q = MODULUS-1, wrap mode: q <= 0, wrap_p=1 next cycle, ovf set.
  - If q = MODULUS-1, sat mode: q holds, wrap_p=1, ovf set.
- Step, down (up_dn=0):
  - If q > 0: q <= q-1.
  - If q = 0, wrap mode: q <= MODULUS-1, wrap_p=1, unf set.
  - If q = 0, sat mode: q holds, wrap_p=1, unf set.
- wrap_p is high for exactly one cycle per boundary event. It re-asserts on every subsequent saturated tick.
- tc = (up_dn ? q==MODULUS-1 : q==0). It is independent of en.
- Flags:
  - clr_flags clears ovf and unf.
  - A set event in the same cycle as clr_flags wins: the flag ends at 1.
- Changing up_dn or sat_mode mid-prescale does not reset the prescaler. The new value applies at the next tick.
- Width rule: all comparisons are done at WIDTH bits. MODULUS=2**WIDTH is legal; the wrap then matches natural rollover.
- rst asserted mid-count overrides everything in that cycle.
- Illegal parameters are caught by an elaboration-time check: $error if MODULUS>2**WIDTH, MODULUS<2, PRESCALE<1, or RESET_VAL>=MODULUS.

Optional Feature:
- Macro: COUNTER_GRAY_OUT_EN.
- Defined: adds output port q_gray [WIDTH], a registered Gray encoding of the next value of q (q_next ^ (q_next>>1)), updated in the same cycle as q. Reset value = Gray(RESET_VAL). This is intended for clock-domain-crossing consumers.
- Undefined: the port and its register are absent; all other behaviour is identical.

Decomposition:
- Package counter_pkg holds:
  - function bin2gray.
  - localparam-style helper function for PRESCALE counter width, clog2 with a minimum of 1.
  - enum cnt_mode_e {CNT_WRAP, CNT_SAT}, used internally for sat_mode decoding.
- One sub-module: counter_prescaler (params PRESCALE; ports clk, rst, en, clr, tick). It is instantiated once, with clr driven by load.

Test Plan:
1. WIDTH=4, MODULUS=10, PRESCALE=1, wrap mode, up, en=1 from q=0 → q steps 0..9 then 0. wrap_p high the cycle after the 9→0 step. tc=1 while q=9. ovf=1.
2. Same config, down, sat mode, load_val=2 → q 2,1,0,0,0. wrap_p pulses on each tick at 0. unf=1. tc=1 at q=0.
3. PRESCALE=3, up, en=1 → q increments every 3rd cycle. Dropping en for 2 cycles mid-prescale delays the next step by exactly 2 cycles.
4. load=1 with load_val=15 while MODULUS=10 and en=1 → q=9 next cycle, no step taken, prescaler restarts, wrap_p=0.
5. Set ovf, then assert clr_flags in the same cycle as a new 9→0 wrap → ovf stays 1. clr_flags alone on a later cycle → ovf=0.
6. Assert rst mid-count at q=6 with load=1 → q=RESET_VAL (0), all flags 0. With COUNTER_GRAY_OUT_EN defined, q_gray tracks bin2gray(q) throughout scenarios 1–6.

Source files
------------

// File: rtl/counter_pkg.sv
// -----------------------------------------------------------------------------
// counter_pkg
// Shared types and helper functions for param_updown_counter and its prescaler.
//   cnt_mode_e     : decoded boundary behaviour (wrap or saturate)
//   prescale_width : width of the prescaler count, clog2 with a minimum of 1
//   bin2gray       : binary to reflected Gray code (32-bit, callers truncate)
// -----------------------------------------------------------------------------
package counter_pkg;

  typedef enum logic [0:0] {
    CNT_WRAP = 1'b0,
    CNT_SAT  = 1'b1
  } cnt_mode_e;

  // A PRESCALE of 1 still needs one bit so the count register is never zero-width.
  function automatic int prescale_width(input int p);
    int w;
    if (p <= 32'sd1) begin
      w = 32'sd1;
    end else begin
      w = $clog2(p);
    end
    return w;
  endfunction

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/counter_prescaler.sv
// -----------------------------------------------------------------------------
// counter_prescaler
// Divides enabled cycles by PRESCALE and emits a one-cycle step tick.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous reset, active-high (count returns to 0)
//   en   : advance enable
//   clr  : synchronous restart of the count (has priority over en)
//   tick : high in an enabled, non-cleared cycle whose count is PRESCALE-1
// -----------------------------------------------------------------------------
module counter_prescaler
  import counter_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int            PW   = prescale_width(PRESCALE);
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] cnt_q;
  logic [PW-1:0] cnt_d;
  logic          at_last_s;

  assign at_last_s = (cnt_q == LAST);
  assign tick      = en & ~clr & at_last_s;

  // Next prescale count: restart on clr, roll over at LAST, freeze when disabled.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = {PW{1'b0}};
    end else if (en) begin
      if (at_last_s) begin
        cnt_d = {PW{1'b0}};
      end else begin
        cnt_d = cnt_q + {{(PW-1){1'b0}}, 1'b1};
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Prescale count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= {PW{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/param_updown_counter.sv
// -----------------------------------------------------------------------------
// param_updown_counter
// Up/down counter over 0..MODULUS-1 with load, prescaled enable and a choice of
// wrap or saturate at the boundaries.
// Ports:
//   clk, rst    : clock (rising edge), synchronous active-high reset
//   en          : count enable (gates the prescaler)
//   up_dn       : 1 = count up, 0 = count down
//   sat_mode    : 1 = saturate at boundary, 0 = wrap
//   load        : synchronous load strobe, load_val clamped to MODULUS-1
//   load_val    : value to load
//   clr_flags   : clears sticky ovf/unf (a same-cycle set wins)
//   q           : registered count
//   tc          : terminal count, combinational from q and up_dn
//   wrap_p      : registered one-cycle pulse per boundary event
//   ovf, unf    : sticky upward / downward boundary flags
//   q_gray      : only with COUNTER_GRAY_OUT_EN defined; registered Gray code
//                 of the next count, so it changes in the same cycle as q
// -----------------------------------------------------------------------------
module param_updown_counter
  import counter_pkg::*;
#(
  parameter int     WIDTH     = 4,
  parameter longint MODULUS   = 16,
  parameter int     PRESCALE  = 1,
  parameter longint RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             sat_mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_flags,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap_p,
  output logic             ovf,
  output logic             unf
`ifdef COUNTER_GRAY_OUT_EN
  ,
  output logic [WIDTH-1:0] q_gray
`endif
);

  if ((MODULUS < 64'sd2) || (MODULUS > (64'sd1 <<< WIDTH)) ||
      (PRESCALE < 32'sd1) || (RESET_VAL >= MODULUS) || (RESET_VAL < 64'sd0)) begin : g_bad_params
    $error("param_updown_counter: illegal parameters WIDTH=%0d MODULUS=%0d PRESCALE=%0d RESET_VAL=%0d",
           WIDTH, MODULUS, PRESCALE, RESET_VAL);
  end

  // All boundary tests are made at WIDTH bits; MODULUS=2**WIDTH gives MAX_VAL=all ones.
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 64'sd1);
  localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] ZERO    = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             wrap_q, wrap_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             tick_s;
  logic             at_max_s;
  logic             at_min_s;
  cnt_mode_e        mode_s;

  // The prescaler restarts on load so a load never shares a cycle with a step.
  counter_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .clr  (load),
    .tick (tick_s)
  );

  assign mode_s   = sat_mode ? CNT_SAT : CNT_WRAP;
  assign at_max_s = (cnt_q == MAX_VAL);
  assign at_min_s = (cnt_q == ZERO);

  assign q      = cnt_q;
  assign tc     = up_dn ? at_max_s : at_min_s;
  assign wrap_p = wrap_q;
  assign ovf    = ovf_q;
  assign unf    = unf_q;

  // Next count and flags; load beats step, a boundary set beats clr_flags.
  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    ovf_d  = ovf_q & ~clr_flags;
    unf_d  = unf_q & ~clr_flags;
    if (load) begin
      cnt_d = (load_val > MAX_VAL) ? MAX_VAL : load_val;
    end else if (tick_s) begin
      if (up_dn) begin
        if (at_max_s) begin
          wrap_d = 1'b1;
          ovf_d  = 1'b1;
          case (mode_s)
            CNT_WRAP: cnt_d = ZERO;
            CNT_SAT:  cnt_d = cnt_q;
            default:  cnt_d = cnt_q;
          endcase
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end else begin
        if (at_min_s) begin
          wrap_d = 1'b1;
          unf_d  = 1'b1;
          case (mode_s)
            CNT_WRAP: cnt_d = MAX_VAL;
            CNT_SAT:  cnt_d = cnt_q;
            default:  cnt_d = cnt_q;
          endcase
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count, pulse and sticky flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= RST_VAL;
      wrap_q <= 1'b0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
    end
  end

`ifdef COUNTER_GRAY_OUT_EN
  logic [WIDTH-1:0] gray_q;

  assign q_gray = gray_q;

  // Gray copy encoded from cnt_d so it is registered alongside q, not a cycle late.
  always_ff @(posedge clk) begin
    if (rst) begin
      gray_q <= WIDTH'(bin2gray(32'(RST_VAL)));
    end else begin
      gray_q <= WIDTH'(bin2gray(32'(cnt_d)));
    end
  end
`endif

endmodule

// File: tb/tb_param_updown_counter.sv
// -----------------------------------------------------------------------------
// tb_param_updown_counter
// Two counters (PRESCALE 1 and 3, WIDTH 4, MODULUS 10) share one stimulus
// stream: directed scenarios followed by random traffic, each cycle compared
// with a behavioural model of the counting rules.
// -----------------------------------------------------------------------------
module tb_param_updown_counter;

  localparam int MOD = 10;

  logic       clk = 1'b0;
  logic       rst, en, up_dn, sat_mode, load, clr_flags;
  logic [3:0] load_val;

  logic [3:0] q1, q3;
  logic       tc1, tc3, wrap1, wrap3, ovf1, ovf3, unf1, unf3;
`ifdef COUNTER_GRAY_OUT_EN
  logic [3:0] qg1, qg3;
`endif

  int total = 0;
  int bad   = 0;

  // model state per instance: [0] = PRESCALE 1, [1] = PRESCALE 3
  int mq[2];
  int mpc[2];
  int mw[2];
  int mo[2];
  int mu[2];

  always #5 clk = ~clk;

  param_updown_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(1), .RESET_VAL(0)) dut1 (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .sat_mode(sat_mode),
    .load(load), .load_val(load_val), .clr_flags(clr_flags),
    .q(q1), .tc(tc1), .wrap_p(wrap1), .ovf(ovf1), .unf(unf1)
`ifdef COUNTER_GRAY_OUT_EN
    , .q_gray(qg1)
`endif
  );

  param_updown_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(3), .RESET_VAL(0)) dut3 (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .sat_mode(sat_mode),
    .load(load), .load_val(load_val), .clr_flags(clr_flags),
    .q(q3), .tc(tc3), .wrap_p(wrap3), .ovf(ovf3), .unf(unf3)
`ifdef COUNTER_GRAY_OUT_EN
    , .q_gray(qg3)
`endif
  );

  task automatic chk(input string name, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", name, obs, exp);
    end
  endtask

  function automatic int ps(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  // Apply one clock of the counting rules to the model using the current inputs.
  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        mq[i] = 0; mpc[i] = 0; mw[i] = 0; mo[i] = 0; mu[i] = 0;
      end else begin
        mw[i] = 0;
        if (clr_flags) begin
          mo[i] = 0;
          mu[i] = 0;
        end
        if (load) begin
          mq[i]  = (int'(load_val) > MOD - 1) ? MOD - 1 : int'(load_val);
          mpc[i] = 0;
        end else if (en) begin
          mpc[i] = mpc[i] + 1;
          if (mpc[i] == ps(i)) begin
            mpc[i] = 0;
            if (up_dn) begin
              if (mq[i] == MOD - 1) begin
                mw[i] = 1; mo[i] = 1;
                if (!sat_mode) mq[i] = 0;
              end else begin
                mq[i] = mq[i] + 1;
              end
            end else begin
              if (mq[i] == 0) begin
                mw[i] = 1; mu[i] = 1;
                if (!sat_mode) mq[i] = MOD - 1;
              end else begin
                mq[i] = mq[i] - 1;
              end
            end
          end
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    int tce[2];
    for (int i = 0; i < 2; i++) tce[i] = up_dn ? int'(mq[i] == MOD - 1) : int'(mq[i] == 0);
    chk({tag, "_q1"}, int'(q1), mq[0]);
    chk({tag, "_tc1"}, int'(tc1), tce[0]);
    chk({tag, "_wrap1"}, int'(wrap1), mw[0]);
    chk({tag, "_ovf1"}, int'(ovf1), mo[0]);
    chk({tag, "_unf1"}, int'(unf1), mu[0]);
    chk({tag, "_q3"}, int'(q3), mq[1]);
    chk({tag, "_tc3"}, int'(tc3), tce[1]);
    chk({tag, "_wrap3"}, int'(wrap3), mw[1]);
    chk({tag, "_ovf3"}, int'(ovf3), mo[1]);
    chk({tag, "_unf3"}, int'(unf3), mu[1]);
`ifdef COUNTER_GRAY_OUT_EN
    chk({tag, "_gray1"}, int'(qg1), mq[0] ^ (mq[0] >> 1));
    chk({tag, "_gray3"}, int'(qg3), mq[1] ^ (mq[1] >> 1));
`endif
  endtask

  task automatic drive(input bit e, input bit u, input bit s, input bit l,
                       input logic [3:0] v, input bit c, input bit r);
    en = e; up_dn = u; sat_mode = s; load = l; load_val = v; clr_flags = c; rst = r;
  endtask

  task automatic cyc(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      mq[i] = 0; mpc[i] = 0; mw[i] = 0; mo[i] = 0; mu[i] = 0;
    end

    // reset
    drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
    cyc("rst");
    cyc("rst");
    chk("rst_q_is_0", int'(q1), 0);

    // 1: up, wrap, count 0..9 then 0
    drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    repeat (9) cyc("s1");
    chk("s1_q_at_9", int'(q1), 9);
    chk("s1_tc_at_9", int'(tc1), 1);
    cyc("s1");
    chk("s1_wrap_to_0", int'(q1), 0);
    chk("s1_wrap_pulse", int'(wrap1), 1);
    chk("s1_ovf_set", int'(ovf1), 1);

    // 2: load 2, down, saturate at 0
    drive(1'b0, 1'b0, 1'b1, 1'b1, 4'd2, 1'b0, 1'b0);
    cyc("s2_load");
    drive(1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    repeat (5) cyc("s2");
    chk("s2_q_sat_0", int'(q1), 0);
    chk("s2_wrap_repeat", int'(wrap1), 1);
    chk("s2_unf_set", int'(unf1), 1);
    chk("s2_tc_at_0", int'(tc1), 1);

    // 3: prescaled up count with en dropped mid-prescale
    drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    repeat (4) cyc("s3");
    drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    repeat (2) cyc("s3_hold");
    drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    repeat (7) cyc("s3");

    // 4: load beyond modulus clamps to 9, no step
    drive(1'b1, 1'b1, 1'b0, 1'b1, 4'd15, 1'b0, 1'b0);
    cyc("s4");
    chk("s4_clamp1", int'(q1), 9);
    chk("s4_clamp3", int'(q3), 9);
    chk("s4_no_wrap", int'(wrap1), 0);

    // 5: clr_flags coinciding with a wrap keeps ovf, alone clears it
    drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    cyc("s5");
    chk("s5_set_wins", int'(ovf1), 1);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    cyc("s5_clr");
    chk("s5_ovf_cleared", int'(ovf1), 0);

    // 6: rst with load at q=6
    drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    repeat (6) cyc("s6");
    chk("s6_q_at_6", int'(q1), 6);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 4'd3, 1'b0, 1'b1);
    cyc("s6_rst");
    chk("s6_rst_q", int'(q1), 0);
    chk("s6_rst_ovf", int'(ovf1), 0);
    chk("s6_rst_unf", int'(unf1), 0);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      drive(bit'($urandom_range(0, 9) < 7), bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
            bit'($urandom_range(0, 9) == 0), 4'($urandom_range(0, 15)),
            bit'($urandom_range(0, 7) == 0), bit'($urandom_range(0, 49) == 0));
      cyc("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
